// File: rtl/counter_event_fifo.sv
// counter_event_fifo: turns rising edges of the counter's max/zero flags into
// typed events and buffers them in a first-word-fall-through FIFO with drop accounting.
module counter_event_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero_flag,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_type,
    output logic [WIDTH-1:0] ev_value,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic             max_q, zero_q;
    logic             rise_max, rise_zero, ev_new;
    logic             full, empty, push, pop, drop;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [1:0]       type_mem  [DEPTH];
    logic [WIDTH-1:0] value_mem [DEPTH];

    assign rise_max  = max_count & ~max_q;
    assign rise_zero = zero_flag & ~zero_q;
    assign ev_new    = rise_max | rise_zero;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = ev_valid & ev_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts the event
    assign push      = ev_new & (~full | pop);
    assign drop      = ev_new & full & ~pop;

    assign ev_valid  = ~empty;
    assign ev_type   = empty ? 2'b00 : type_mem[rd_ptr[AW-1:0]];
    assign ev_value  = empty ? '0 : value_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q    <= 1'b1;
            zero_q   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            max_q    <= max_count;
            zero_q   <= zero_flag;
            wr_ptr   <= push ? wr_ptr + (AW+1)'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
            overflow <= overflow | drop;
            drop_cnt <= (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr[AW-1:0]]  <= {rise_zero, rise_max};
            value_mem[wr_ptr[AW-1:0]] <= count_out;
        end
    end
endmodule

// File: tb/tb_counter_event_fifo.sv
// tb_counter_event_fifo: directed scenarios plus randomized traffic checked
// against a queue-based model of the event FIFO.
module tb_counter_event_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] count_out = '0;
    logic             max_count = 1'b0;
    logic             zero_flag = 1'b0;
    logic             ev_ready = 1'b0;
    logic             ev_valid;
    logic [1:0]       ev_type;
    logic [WIDTH-1:0] ev_value;
    logic             overflow;
    logic [7:0]       drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [WIDTH+1:0] mq[$];
    logic             m_max_q, m_zero_q, m_ovf;
    int               m_drop;

    counter_event_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .count_out(count_out), .max_count(max_count),
        .zero_flag(zero_flag), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_type(ev_type), .ev_value(ev_value), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_max_q = 1'b1;
        m_zero_q = 1'b1;
        m_ovf = 1'b0;
        m_drop = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT
    task automatic tick();
        logic rmax, rzero;
        rmax = max_count & ~m_max_q;
        rzero = zero_flag & ~m_zero_q;
        if (mq.size() != 0 && ev_ready) void'(mq.pop_front());
        if (rmax | rzero) begin
            if (mq.size() < DEPTH) mq.push_back({rzero, rmax, count_out});
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_max_q = max_count;
        m_zero_q = zero_flag;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        checks++;
        if (ev_valid !== 1'b0 || ev_type !== 2'b00 || ev_value !== '0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b type=%b value=%h ovf=%b drop=%0d, want all 0", ev_valid, ev_type, ev_value, overflow, drop_cnt);
        end
        zero_flag = 1'b1;
        max_count = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_event: ev_valid=%b want 0", ev_valid);
        end
    endtask

    task automatic test_single_max();
        zero_flag = 1'b0;
        count_out = 16'h0001;
        tick();
        ev_ready = 1'b1;
        count_out = 16'hFFFF;
        max_count = 1'b1;
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_type !== 2'b01 || ev_value !== 16'hFFFF) begin
            errors++;
            $display("FAIL single_max: valid=%b type=%b value=%h want 1/01/ffff", ev_valid, ev_type, ev_value);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_max_pop: ev_valid=%b want 0 (held flag must not re-fire)", ev_valid);
        end
        max_count = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] vals[6];
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vals[i] = WIDTH'($urandom);
            count_out = vals[i];
            max_count = 1'b1;
            tick();
            max_count = 1'b0;
            tick();
        end
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overflow_count: ovf=%b drop=%0d want 1/2", overflow, drop_cnt);
        end
        checks++;
        if (ev_value !== vals[0]) begin
            errors++;
            $display("FAIL stall_stable: value=%h want %h", ev_value, vals[0]);
        end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_type !== 2'b01 || ev_value !== vals[i]) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b type=%b value=%h want 1/01/%h", i, ev_valid, ev_type, ev_value, vals[i]);
            end
            tick();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: ev_valid=%b want 0", ev_valid);
        end
    endtask

    task automatic test_full_push_pop();
        int n;
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            count_out = WIDTH'(16'h100 + i);
            max_count = 1'b1;
            tick();
            max_count = 1'b0;
            tick();
        end
        ev_ready = 1'b1;
        max_count = 1'b1;
        count_out = 16'hBEEF;
        tick();
        max_count = 1'b0;
        checks++;
        if (drop_cnt !== 8'd2 || ev_value !== 16'h0101) begin
            errors++;
            $display("FAIL full_push_pop: drop=%0d head=%h want 2/0101", drop_cnt, ev_value);
        end
        n = 0;
        while (ev_valid === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL full_occupancy: drained=%0d want 4", n);
        end
    endtask

    task automatic test_both();
        ev_ready = 1'b0;
        max_count = 1'b0;
        zero_flag = 1'b0;
        tick();
        count_out = 16'h0000;
        max_count = 1'b1;
        zero_flag = 1'b1;
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_type !== 2'b11 || ev_value !== 16'h0000) begin
            errors++;
            $display("FAIL both_edges: valid=%b type=%b value=%h want 1/11/0000", ev_valid, ev_type, ev_value);
        end
        ev_ready = 1'b1;
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_single_entry: ev_valid=%b want 0", ev_valid);
        end
        max_count = 1'b0;
        zero_flag = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [1:0]       e_type;
        logic [WIDTH-1:0] e_value;
        for (int c = 0; c < 400; c++) begin
            max_count = ($urandom_range(0, 2) == 0);
            zero_flag = ($urandom_range(0, 2) == 0);
            count_out = WIDTH'($urandom);
            ev_ready = ($urandom_range(0, 3) == 0);
            tick();
            e_type = mq.size() != 0 ? mq[0][WIDTH+1:WIDTH] : 2'b00;
            e_value = mq.size() != 0 ? mq[0][WIDTH-1:0] : '0;
            checks++;
            if (ev_valid !== (mq.size() != 0) || ev_type !== e_type || ev_value !== e_value
                || overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL random_c%0d: got %b/%b/%h/%b/%0d want %b/%b/%h/%b/%0d", c,
                         ev_valid, ev_type, ev_value, overflow, drop_cnt,
                         mq.size() != 0, e_type, e_value, m_ovf, m_drop);
            end
        end
        ev_ready = 1'b1;
        max_count = 1'b0;
        zero_flag = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset_mid();
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            count_out = WIDTH'(16'h200 + i);
            zero_flag = 1'b1;
            tick();
            zero_flag = 1'b0;
            tick();
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++;
        if (ev_valid !== 1'b1 || overflow !== 1'b1 || mq.size() != 3) begin
            errors++;
            $display("FAIL pre_reset: valid=%b ovf=%b model_depth=%0d want 1/1/3", ev_valid, overflow, mq.size());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ev_valid !== 1'b0 || ev_type !== 2'b00 || ev_value !== '0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b type=%b value=%h ovf=%b drop=%0d want all 0", ev_valid, ev_type, ev_value, overflow, drop_cnt);
        end
        max_count = 1'b1;
        zero_flag = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ev_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_stale_%0d: ev_valid=%b want 0", i, ev_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_max();
        test_overflow();
        test_full_push_pop();
        test_both();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
